// File: rtl/dbg_probe_pkg.sv
// Shared constants, register-map bit positions and FSM state type for the
// JTAG debug register-file probe.
package dbg_probe_pkg;

   localparam logic [1:0] ADDR_DATA   = 2'd0;
   localparam logic [1:0] ADDR_STATUS = 2'd1;
   localparam logic [1:0] ADDR_CTRL   = 2'd2;

   localparam int ST_VALID   = 0;
   localparam int ST_BUSY    = 1;
   localparam int ST_TIMEOUT = 2;
   localparam int ST_HALTED  = 3;
   localparam int ST_PENDING = 4;
   localparam int ST_IDX_LSB = 8;
   localparam int ST_CNT_LSB = 16;

   localparam int CTRL_START   = 0;
   localparam int CTRL_AUTO_EN = 1;
   localparam int CTRL_CLR_ERR = 2;

   typedef enum logic {
      IDLE,
      WAIT_ACK
   } probe_state_e;

   // The sample count occupies the upper half-word; narrower counters arrive zero-extended.
   function automatic logic [31:0] pack_status(
      input logic       valid,
      input logic       busy,
      input logic       timeout,
      input logic       halted,
      input logic       pending,
      input logic [4:0] idx,
      input logic [15:0] cnt
   );
      logic [31:0] w;
      w = '0;
      w[ST_VALID]          = valid;
      w[ST_BUSY]           = busy;
      w[ST_TIMEOUT]        = timeout;
      w[ST_HALTED]         = halted;
      w[ST_PENDING]        = pending;
      w[ST_IDX_LSB +: 5]   = idx;
      w[ST_CNT_LSB +: 16]  = cnt;
      return w;
   endfunction

endpackage

// File: rtl/dbg_probe_regs.sv
// Avalon-MM slave front end: CTRL write decode into strobes, stored auto_en,
// and the zero-wait-state readdata mux.
module dbg_probe_regs
   import dbg_probe_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       address_i,
   input  logic             chipselect_i,
   input  logic             write_n_i,
   input  logic [31:0]      writedata_i,
   input  logic [31:0]      data_i,
   input  logic             valid_i,
   input  logic             busy_i,
   input  logic             timeout_i,
   input  logic             halted_i,
   input  logic             pending_i,
   input  logic [4:0]       idx_i,
   input  logic [CNT_W-1:0] count_i,
   output logic             start_o,
   output logic             clear_err_o,
   output logic             auto_en_o,
   output logic [31:0]      readdata_o
);

   logic ctrl_wr;
   logic auto_en_q;
   logic auto_en_d;

   assign ctrl_wr     = chipselect_i && !write_n_i && (address_i == ADDR_CTRL);
   assign start_o     = ctrl_wr && writedata_i[CTRL_START];
   assign clear_err_o = ctrl_wr && writedata_i[CTRL_CLR_ERR];
   assign auto_en_o   = auto_en_q;

   always_comb begin
      auto_en_d = auto_en_q;
      if (ctrl_wr) begin
         auto_en_d = writedata_i[CTRL_AUTO_EN];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         auto_en_q <= 1'b0;
      end else begin
         auto_en_q <= auto_en_d;
      end
   end

   // CTRL is write-only and address 3 is unmapped; both read back as zero.
   always_comb begin
      readdata_o = '0;
      case (address_i)
         ADDR_DATA:   readdata_o = data_i;
         ADDR_STATUS: readdata_o = pack_status(valid_i, busy_i, timeout_i, halted_i,
                                               pending_i, idx_i, 16'(count_i));
         default:     readdata_o = '0;
      endcase
   end

endmodule

// File: rtl/dbg_regfile_probe.sv
// Reads one RISC-V GPR through the core's halted-mode debug port on request
// and publishes the captured value and status to the JTAG Avalon master.
module dbg_regfile_probe
   import dbg_probe_pkg::*;
#(
   parameter int TIMEOUT_W = 8,
   parameter int CNT_W     = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  reg_sel,
   input  logic        core_halted,
   output logic        dbg_req,
   output logic [4:0]  dbg_addr,
   input  logic        dbg_ack,
   input  logic [31:0] dbg_rdata,
   input  logic [1:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [31:0] writedata,
   output logic [31:0] readdata
);

   // Last timer value before giving up; the request is held for 2**TIMEOUT_W-1 cycles.
   localparam logic [TIMEOUT_W-1:0] TIMER_LAST = {TIMEOUT_W{1'b1}} - 1'b1;

   probe_state_e         state_q, state_d;
   logic [4:0]           idx_q, idx_d;
   logic [4:0]           cap_idx_q, cap_idx_d;
   logic [4:0]           last_sel_q;
   logic [31:0]          data_q, data_d;
   logic                 valid_q, valid_d;
   logic                 timeout_q, timeout_d;
   logic                 pending_q, pending_d;
   logic [CNT_W-1:0]     count_q, count_d;
   logic [TIMEOUT_W-1:0] timer_q, timer_d;

   logic start;
   logic clear_err;
   logic auto_en;
   logic trigger;

   dbg_probe_regs #(
      .CNT_W (CNT_W)
   ) u_regs (
      .clk          (clk),
      .reset        (reset),
      .address_i    (address),
      .chipselect_i (chipselect),
      .write_n_i    (write_n),
      .writedata_i  (writedata),
      .data_i       (data_q),
      .valid_i      (valid_q),
      .busy_i       (state_q == WAIT_ACK),
      .timeout_i    (timeout_q),
      .halted_i     (core_halted),
      .pending_i    (pending_q),
      .idx_i        (cap_idx_q),
      .count_i      (count_q),
      .start_o      (start),
      .clear_err_o  (clear_err),
      .auto_en_o    (auto_en),
      .readdata_o   (readdata)
   );

   assign trigger  = start || (auto_en && (reg_sel != last_sel_q));
   assign dbg_req  = (state_q == WAIT_ACK);
   assign dbg_addr = idx_q;

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      cap_idx_d = cap_idx_q;
      data_d    = data_q;
      valid_d   = valid_q;
      timeout_d = timeout_q;
      pending_d = pending_q;
      count_d   = count_q;
      timer_d   = timer_q;

      if (clear_err) begin
         timeout_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            timer_d = '0;
            if (pending_q && core_halted) begin
               idx_d     = reg_sel;
               pending_d = 1'b0;
               valid_d   = 1'b0;
               // x0 is hardwired to zero, so it completes without a bus read.
               if (reg_sel == 5'd0) begin
                  data_d    = '0;
                  cap_idx_d = 5'd0;
                  valid_d   = 1'b1;
                  count_d   = count_q + 1'b1;
               end else begin
                  state_d = WAIT_ACK;
               end
            end
         end
         WAIT_ACK: begin
            if (dbg_ack) begin
               data_d    = dbg_rdata;
               cap_idx_d = idx_q;
               valid_d   = 1'b1;
               count_d   = count_q + 1'b1;
               state_d   = IDLE;
            end else if (timer_q == TIMER_LAST) begin
               timeout_d = 1'b1;
               state_d   = IDLE;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // A trigger arriving alongside a launch or capture still queues a fresh read.
      if (trigger) begin
         pending_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         cap_idx_q  <= '0;
         last_sel_q <= '0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         timeout_q  <= 1'b0;
         pending_q  <= 1'b0;
         count_q    <= '0;
         timer_q    <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         cap_idx_q  <= cap_idx_d;
         last_sel_q <= reg_sel;
         data_q     <= data_d;
         valid_q    <= valid_d;
         timeout_q  <= timeout_d;
         pending_q  <= pending_d;
         count_q    <= count_d;
         timer_q    <= timer_d;
      end
   end

endmodule
